// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit between the pipeline and a synchronous data memory.
//
// Stores and misaligned requests are handled in the cycle they are accepted.
// Loads present the word address in the accept cycle. They return a lane-extracted,
// extended result in the following cycle. The result is held until the consumer
// takes it. A misaligned access raises a one-cycle address-error pulse.
//
// Ports
//    clk              sole clock, rising edge
//    rst              asynchronous reset, active low
//    req_valid        request present from the pipeline
//    req_ready        lsu accepts a request this cycle (IDLE only)
//    req_we           1 = store, 0 = load
//    req_size         00 byte, 01 half, 10 word, 11 illegal
//    req_unsigned     zero-extend byte/half loads
//    req_addr         byte address
//    req_wdata        right-justified store data
//    req_rd           destination register tag of a load
//    mem_addr         word address to data memory
//    mem_we           data memory write enable
//    mem_win          lane-replicated write data
//    mem_wbyte_enable per-lane byte enables (bit i -> mem_win[8i+7:8i])
//    mem_dout         memory read word, valid one cycle after the address
//    rsp_valid        load result available
//    rsp_ready        consumer takes the result
//    rsp_data         extended load result
//    rsp_rd           tag of rsp_data
//    exc_valid        one-cycle address-error pulse
//    exc_addr         faulting byte address
//    exc_store        1 = store fault, 0 = load fault
// -----------------------------------------------------------------------------
module lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_win,
   output logic [3:0]  mem_wbyte_enable,
   input  logic [31:0] mem_dout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        exc_valid,
   output logic [31:0] exc_addr,
   output logic        exc_store
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RESP_HOLD = 2'd2
   } state_t;

   state_t      r_state;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [4:0]  r_rd;
   logic [31:0] r_hold_data;
   logic [4:0]  r_hold_rd;
   logic        r_exc_valid;
   logic [31:0] r_exc_addr;
   logic        r_exc_store;

   logic        w_accept;
   logic        w_misaligned;
   logic        w_store_ok;
   logic [3:0]  w_be;
   logic [31:0] w_win;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   assign req_ready = (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;

   // Alignment check. An illegal size faults at any address.
   always_comb begin
      w_misaligned = 1'b0;
      case (req_size)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
         default: w_misaligned = 1'b1;
      endcase
   end

   // Store data is replicated across lanes. The byte enables pick the lane(s)
   // that the little-endian address offset selects.
   always_comb begin
      w_be  = 4'b0000;
      w_win = req_wdata;
      case (req_size)
         2'b00: begin
            w_be  = 4'b0001 << req_addr[1:0];
            w_win = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be  = req_addr[1] ? 4'b1100 : 4'b0011;
            w_win = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            w_be  = 4'b1111;
            w_win = req_wdata;
         end
         default: begin
            w_be  = 4'b0000;
            w_win = req_wdata;
         end
      endcase
   end

   // The memory is written only in an accept cycle of an aligned store.
   assign w_store_ok       = w_accept && req_we && !w_misaligned;
   assign mem_addr         = {req_addr[31:2], 2'b00};
   assign mem_we           = w_store_ok;
   assign mem_win          = w_win;
   assign mem_wbyte_enable = w_store_ok ? w_be : 4'b0000;

   // Pick the addressed lane out of the returned word, then extend it.
   always_comb begin
      w_byte      = mem_dout[{r_off, 3'b000} +: 8];
      w_half      = r_off[1] ? mem_dout[31:16] : mem_dout[15:0];
      w_load_data = mem_dout;
      case (r_size)
         2'b00:   w_load_data = r_unsigned ? {24'h0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load_data = r_unsigned ? {16'h0, w_half}
                                           : {{16{w_half[15]}}, w_half};
         default: w_load_data = mem_dout;
      endcase
   end

   // In LOAD_WAIT the result comes straight from memory. In RESP_HOLD it comes
   // from the hold register, because mem_dout is no longer guaranteed.
   always_comb begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
      rsp_rd    = 5'h0;
      case (r_state)
         LOAD_WAIT: begin
            rsp_valid = 1'b1;
            rsp_data  = w_load_data;
            rsp_rd    = r_rd;
         end
         RESP_HOLD: begin
            rsp_valid = 1'b1;
            rsp_data  = r_hold_data;
            rsp_rd    = r_hold_rd;
         end
         default: begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
            rsp_rd    = 5'h0;
         end
      endcase
   end

   assign exc_valid = r_exc_valid;
   assign exc_addr  = r_exc_addr;
   assign exc_store = r_exc_store;

   // Main sequencer. The exception pulse lasts one cycle because r_exc_valid
   // is rewritten on every edge. Reset drops any load in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_off       <= 2'b00;
         r_size      <= 2'b00;
         r_unsigned  <= 1'b0;
         r_rd        <= 5'h0;
         r_hold_data <= 32'h0;
         r_hold_rd   <= 5'h0;
         r_exc_valid <= 1'b0;
         r_exc_addr  <= 32'h0;
         r_exc_store <= 1'b0;
      end else begin
         r_exc_valid <= w_accept && w_misaligned;
         case (r_state)
            IDLE: begin
               if (w_accept && w_misaligned) begin
                  r_exc_addr  <= req_addr;
                  r_exc_store <= req_we;
               end else if (w_accept && !req_we) begin
                  r_off      <= req_addr[1:0];
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_rd       <= req_rd;
                  r_state    <= LOAD_WAIT;
               end
            end
            LOAD_WAIT: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end else begin
                  r_hold_data <= w_load_data;
                  r_hold_rd   <= r_rd;
                  r_state     <= RESP_HOLD;
               end
            end
            RESP_HOLD: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for the load/store unit.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, well away
// from the rising edge. Expected values come from a table of known vectors
// and from an arithmetic reference model for random requests.
// -----------------------------------------------------------------------------
module tb_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_win;
   logic [3:0]  mem_wbyte_enable;
   logic [31:0] mem_dout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        exc_valid;
   logic [31:0] exc_addr;
   logic        exc_store;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] dout;
      logic        expExc;
      logic        expMemWe;
      logic [3:0]  expBe;
      logic [31:0] expWin;
      logic [31:0] expData;
   } vec_t;

   lsu dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_size         (req_size),
      .req_unsigned     (req_unsigned),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_rd           (req_rd),
      .mem_addr         (mem_addr),
      .mem_we           (mem_we),
      .mem_win          (mem_win),
      .mem_wbyte_enable (mem_wbyte_enable),
      .mem_dout         (mem_dout),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .rsp_rd           (rsp_rd),
      .exc_valid        (exc_valid),
      .exc_addr         (exc_addr),
      .exc_store        (exc_store)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model built from the access rules using plain arithmetic
   function automatic vec_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [4:0] rd, input logic [31:0] dout);
      vec_t v;
      int unsigned off;
      int unsigned b;
      int unsigned h;
      off = addr % 4;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr;
      v.wdata = wdata; v.rd = rd; v.dout = dout;
      v.expExc = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
                 (size == 2'd2 && off != 0);
      v.expMemWe = we && !v.expExc;
      v.expBe = 4'h0;
      v.expWin = wdata;
      if (size == 2'd0) v.expWin = (wdata % 256) * 32'h01010101;
      if (size == 2'd1) v.expWin = (wdata % 65536) * 32'h00010001;
      if (v.expMemWe) begin
         if (size == 2'd0) v.expBe = 4'(1 << off);
         else if (size == 2'd1) v.expBe = (off >= 2) ? 4'hC : 4'h3;
         else v.expBe = 4'hF;
      end
      b = (dout >> (8 * off)) % 256;
      h = (dout >> (16 * (off / 2))) % 65536;
      if (size == 2'd0) v.expData = (!uns && b >= 128) ? b + 32'hFFFFFF00 : b;
      else if (size == 2'd1) v.expData = (!uns && h >= 32768) ? h + 32'hFFFF0000 : h;
      else v.expData = dout;
      return v;
   endfunction

   // Drive one request from the falling edge. Check the accept-cycle memory
   // side, then the exception or load response in the following cycle.
   task automatic applyStimulus(input vec_t v, input string tag);
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
      mem_dout = $urandom;
      #1;
      checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, " mem_addr"}, mem_addr, v.addr & 32'hFFFFFFFC);
      checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(v.expMemWe));
      checkOutput({tag, " be"}, 32'(mem_wbyte_enable), 32'(v.expBe));
      if (v.expMemWe) checkOutput({tag, " win"}, mem_win, v.expWin);
      @(negedge clk);
      req_valid = 1'b0;
      mem_dout = v.dout;
      #1;
      checkOutput({tag, " mem_we idle"}, 32'(mem_we), 32'd0);
      checkOutput({tag, " exc_valid"}, 32'(exc_valid), 32'(v.expExc));
      if (v.expExc) begin
         checkOutput({tag, " exc_addr"}, exc_addr, v.addr);
         checkOutput({tag, " exc_store"}, 32'(exc_store), 32'(v.we));
         checkOutput({tag, " exc rsp_valid"}, 32'(rsp_valid), 32'd0);
      end else if (!v.we) begin
         checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
         checkOutput({tag, " rsp_data"}, rsp_data, v.expData);
         checkOutput({tag, " rsp_rd"}, 32'(rsp_rd), 32'(v.rd));
         checkOutput({tag, " busy"}, 32'(req_ready), 32'd0);
      end else begin
         checkOutput({tag, " store rsp_valid"}, 32'(rsp_valid), 32'd0);
         checkOutput({tag, " store req_ready"}, 32'(req_ready), 32'd1);
      end
   endtask

   vec_t table_v[12];

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
      mem_dout = 32'h0; rsp_ready = 1'b1;

      // Known vectors: we size uns addr wdata rd dout | exc memWe be win data
      table_v[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0,        1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0};
      table_v[1]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 5'd0, 32'h0,        1'b0, 1'b1, 4'h8, 32'hA5A5A5A5, 32'h0};
      table_v[2]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 5'd0, 32'h0,        1'b0, 1'b1, 4'hC, 32'h12341234, 32'h0};
      table_v[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        5'd3, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80};
      table_v[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        5'd4, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'h00000080};
      table_v[5]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        5'd5, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'hFFFF80FF};
      table_v[6]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        5'd6, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'h00007F01};
      table_v[7]  = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        5'd1, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
      table_v[8]  = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h5555,     5'd0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
      table_v[9]  = '{1'b1, 2'd3, 1'b0, 32'h20, 32'h1,        5'd0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
      table_v[10] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        5'd9, 32'h12345678, 1'b0, 1'b0, 4'h0, 32'h0, 32'h12345678};
      table_v[11] = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF3C, 5'd0, 32'h0,        1'b0, 1'b1, 4'h2, 32'h3C3C3C3C, 32'h0};

      // Reset state
      #2;
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset rsp_data", rsp_data, 32'h0);
      checkOutput("reset exc_valid", 32'(exc_valid), 32'd0);
      checkOutput("reset exc_addr", exc_addr, 32'h0);
      checkOutput("reset req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // Known vectors, back to back; consecutive loads run at one per two cycles
      for (int i = 0; i < 12; i++) begin
         applyStimulus(table_v[i], $sformatf("vec%0d", i));
      end
      // A second cycle after an exception must show the pulse gone
      applyStimulus(table_v[7], "exc pulse");
      @(negedge clk); #1;
      checkOutput("exc single-cycle", 32'(exc_valid), 32'd0);

      // Random requests checked against the model
      for (int i = 0; i < 60; i++) begin
         vec_t v;
         logic [1:0] sz;
         sz = 2'($urandom_range(0, 3));
         v = model(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom);
         applyStimulus(v, $sformatf("rnd%0d", i));
      end

      // Result held while the consumer stalls; mem_dout wanders meanwhile
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h40; req_rd = 5'd7;
      @(negedge clk);
      req_valid = 1'b0;
      mem_dout = 32'hCAFEF00D;
      #1;
      checkOutput("hold first data", rsp_data, 32'hCAFEF00D);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_dout = $urandom;
         #1;
         checkOutput("hold rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("hold rsp_data", rsp_data, 32'hCAFEF00D);
         checkOutput("hold rsp_rd", 32'(rsp_rd), 32'd7);
         checkOutput("hold req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      checkOutput("release req_ready", 32'(req_ready), 32'd0);
      checkOutput("release rsp_data", rsp_data, 32'hCAFEF00D);
      @(negedge clk); #1;
      checkOutput("after release rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("after release req_ready", 32'(req_ready), 32'd1);

      // Reset while a load waits discards it
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h80; req_rd = 5'd12;
      @(negedge clk);
      req_valid = 1'b0;
      mem_dout = 32'h11112222;
      #1;
      checkOutput("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("async reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("async reset rsp_data", rsp_data, 32'h0);
      checkOutput("async reset req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checkOutput("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
